// File: rtl/round_sequencer.sv
// round_sequencer: game-level controller for the round countdown timer.
// Arms a round on start, counts seconds down to zero, handles player
// pause/resume, scores correct answers, holds between rounds and flags
// game_over after the last round.
module round_sequencer #(
    parameter int CLK_DIV    = 100000000,
    parameter int ROUND_SECS = 30,
    parameter int HOLD_SECS  = 2,
    parameter int NUM_ROUNDS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause_btn,
    input  logic       answer_valid,
    input  logic       answer_correct,
    output logic [4:0] time_display,
    output logic [3:0] round_num,
    output logic [7:0] score,
    output logic [2:0] state,
    output logic       pause,
    output logic       game_over
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(HOLD_SECS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_PAUSED = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_DIV - 1);
    localparam logic [4:0]    TIME_INIT  = 5'(ROUND_SECS);
    localparam logic [3:0]    LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_SECS - 1);

    logic [2:0]    state_q, state_d;
    logic [4:0]    time_q, time_d;
    logic [3:0]    round_q, round_d;
    logic [7:0]    score_q, score_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          pause_q, pause_d;
    logic          over_q, over_d;

    logic          tick;
    logic [PW-1:0] presc_next;
    logic [7:0]    score_inc;
    logic          correct;

    // One-second tick is the prescaler's wrap cycle; only meaningful in RUN/HOLD
    always_comb begin
        tick       = (presc_q == PRESC_MAX);
        presc_next = tick ? '0 : presc_q + 1'b1;
        score_inc  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
        correct    = answer_valid & answer_correct;
    end

    // Next-state logic; RUN priority is correct answer, then timeout, then pause
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        round_d = round_q;
        score_d = score_q;
        presc_d = presc_q;
        hold_d  = hold_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    round_d = 4'd1;
                    score_d = 8'd0;
                    time_d  = TIME_INIT;
                    presc_d = '0;
                    hold_d  = '0;
                end
            end

            S_RUN: begin
                if (correct) begin
                    // Answer freezes the display even if this was a tick cycle
                    score_d = score_inc;
                    state_d = S_HOLD;
                    presc_d = presc_next;
                    hold_d  = '0;
                end else if (tick && (time_q <= 5'd1)) begin
                    time_d  = 5'd0;
                    state_d = S_HOLD;
                    presc_d = presc_next;
                    hold_d  = '0;
                end else if (pause_btn) begin
                    // Prescaler is frozen from the press so resume keeps the phase
                    state_d = S_PAUSED;
                end else begin
                    presc_d = presc_next;
                    if (tick) begin
                        time_d = time_q - 5'd1;
                    end
                end
            end

            S_PAUSED: begin
                if (pause_btn) begin
                    state_d = S_RUN;
                end
            end

            S_HOLD: begin
                presc_d = presc_next;
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        presc_d = '0;
                        if (round_q >= LAST_ROUND) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RUN;
                            round_d = round_q + 4'd1;
                            time_d  = TIME_INIT;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                time_d  = TIME_INIT;
                round_d = 4'd0;
                score_d = 8'd0;
                presc_d = '0;
                hold_d  = '0;
            end
        endcase

        pause_d = (state_d == S_PAUSED) || (state_d == S_HOLD);
        over_d  = (state_d == S_DONE);
    end

    // State registers with asynchronous reset back to an idle, full-time display
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            time_q  <= TIME_INIT;
            round_q <= 4'd0;
            score_q <= 8'd0;
            presc_q <= '0;
            hold_q  <= '0;
            pause_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            round_q <= round_d;
            score_q <= score_d;
            presc_q <= presc_d;
            hold_q  <= hold_d;
            pause_q <= pause_d;
            over_q  <= over_d;
        end
    end

    assign time_display = time_q;
    assign round_num    = round_q;
    assign score        = score_q;
    assign state        = state_q;
    assign pause        = pause_q;
    assign game_over    = over_q;

endmodule
